// File: rtl/pc_pkg.sv
// Shared types for the fetch PC generator: BTB entry layout, counter encodings, next-PC select.
// Field widths cover the widest legal XLEN so one package serves every parameterisation.
package pc_pkg;

  localparam int unsigned ADDR_MAXW    = 64;
  localparam int unsigned BTB_TAG_MAXW = 64;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_MAXW-1:0] tag;
    logic [ADDR_MAXW-1:0]    target;
    logic [1:0]              ctr;
  } btb_entry_t;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_TRAP,
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_PRED,
    SEL_SEQ
  } npc_sel_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit counters; lookup is combinational (0 cycles).
// Training writes land on the next edge with no bypass; there is no backpressure.
module btb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:2] lookup_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_en_i,
  input  logic [XLEN-1:2] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i
);

  localparam int unsigned IDX = $clog2(BTB_ENTRIES);

  btb_entry_t entries_q [BTB_ENTRIES];

  logic [IDX-1:0]          lk_idx;
  logic [BTB_TAG_MAXW-1:0] lk_tag;
  btb_entry_t              lk_entry;
  logic                    lk_hit;

  logic [IDX-1:0]          up_idx;
  logic [BTB_TAG_MAXW-1:0] up_tag;
  btb_entry_t              up_entry;
  logic                    up_hit;
  btb_entry_t              upd_entry_d;
  logic                    upd_wr;

  // Tags are zero-extended into the fixed-width field and compared in full.
  assign lk_idx   = lookup_pc_i[IDX+1:2];
  assign lk_tag   = BTB_TAG_MAXW'(lookup_pc_i[XLEN-1:IDX+2]);
  assign lk_entry = entries_q[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);

  assign pred_taken_o  = lk_hit && lk_entry.ctr[1];
  assign pred_target_o = pred_taken_o ? lk_entry.target[XLEN-1:0] : '0;

  assign up_idx   = upd_pc_i[IDX+1:2];
  assign up_tag   = BTB_TAG_MAXW'(upd_pc_i[XLEN-1:IDX+2]);
  assign up_entry = entries_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  always_comb begin
    upd_entry_d = up_entry;
    upd_wr      = 1'b0;
    if (upd_en_i) begin
      if (up_hit) begin
        upd_wr          = 1'b1;
        upd_entry_d.ctr = ctr_next(up_entry.ctr, upd_taken_i);
        if (upd_taken_i) begin
          upd_entry_d.target = ADDR_MAXW'(upd_target_i);
        end
      end else if (upd_taken_i) begin
        upd_wr             = 1'b1;
        upd_entry_d.valid  = 1'b1;
        upd_entry_d.tag    = up_tag;
        upd_entry_d.target = ADDR_MAXW'(upd_target_i);
        upd_entry_d.ctr    = CTR_WT;
      end
    end
  end

  // Reset only invalidates; stale tags/targets/counters are unreachable until reallocated.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else if (upd_wr) begin
      entries_q[up_idx] <= upd_entry_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with priority next-PC select and BTB prediction.
// Prediction is combinational from PC (0 cycles); stall holds PC, trap/redirect override stall.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int unsigned BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            RedirectE,
  input  logic [XLEN-1:0] RedirectTargetE,
  input  logic            TrapValid,
  input  logic [XLEN-1:0] TrapTarget,
  input  logic            UpdateEn,
  input  logic [XLEN-1:0] UpdatePC,
  input  logic [XLEN-1:0] UpdateTarget,
  input  logic            UpdateTaken,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  output logic            MisalignF
);

  localparam logic [XLEN-1:0] RST_PC = RESET_VECTOR[XLEN-1:0];

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  npc_sel_e        sel;

  btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i         (clk),
    .rst_ni        (rst),
    .lookup_pc_i   (pc_q[XLEN-1:2]),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_en_i      (UpdateEn),
    .upd_pc_i      (UpdatePC[XLEN-1:2]),
    .upd_target_i  (UpdateTarget),
    .upd_taken_i   (UpdateTaken)
  );

  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    if (!rst) begin
      sel = SEL_RESET;
    end else if (TrapValid) begin
      sel = SEL_TRAP;
    end else if (RedirectE) begin
      sel = SEL_REDIRECT;
    end else if (StallF) begin
      sel = SEL_HOLD;
    end else if (pred_taken) begin
      sel = SEL_PRED;
    end else begin
      sel = SEL_SEQ;
    end
  end

  always_comb begin
    pc_d = pc_plus4;
    case (sel)
      SEL_RESET:    pc_d = RST_PC;
      SEL_TRAP:     pc_d = TrapTarget;
      SEL_REDIRECT: pc_d = RedirectTargetE;
      SEL_HOLD:     pc_d = pc_q;
      SEL_PRED:     pc_d = pred_target;
      default:      pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RST_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign PredTakenF  = pred_taken;
  assign PredTargetF = pred_target;
  assign MisalignF   = |pc_q[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic against an arithmetic BTB/PC model.
module tb_pc_gen;

  localparam logic [63:0] RV = 64'h8000_0000;
  localparam int NENT = 16;

  logic        clk;
  logic        rst;
  logic        StallF, RedirectE, TrapValid, UpdateEn, UpdateTaken;
  logic [63:0] RedirectTargetE, TrapTarget, UpdatePC, UpdateTarget;
  logic [63:0] PC, PCPlus4, PredTargetF;
  logic        PredTakenF, MisalignF;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [63:0] m_pc;
  bit          m_valid [NENT];
  logic [63:0] m_tag   [NENT];
  logic [63:0] m_tgt   [NENT];
  int          m_ctr   [NENT];

  pc_gen #(
    .XLEN         (64),
    .RESET_VECTOR (RV),
    .BTB_ENTRIES  (NENT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .StallF          (StallF),
    .RedirectE       (RedirectE),
    .RedirectTargetE (RedirectTargetE),
    .TrapValid       (TrapValid),
    .TrapTarget      (TrapTarget),
    .UpdateEn        (UpdateEn),
    .UpdatePC        (UpdatePC),
    .UpdateTarget    (UpdateTarget),
    .UpdateTaken     (UpdateTaken),
    .PC              (PC),
    .PCPlus4         (PCPlus4),
    .PredTakenF      (PredTakenF),
    .PredTargetF     (PredTargetF),
    .MisalignF       (MisalignF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_index(input logic [63:0] a);
    return int'((a / 4) % NENT);
  endfunction

  function automatic logic [63:0] m_tagof(input logic [63:0] a);
    return a / (4 * NENT);
  endfunction

  task automatic m_pred(input logic [63:0] a, output bit tk, output logic [63:0] tg);
    int i;
    i  = m_index(a);
    tk = m_valid[i] && (m_tag[i] == m_tagof(a)) && (m_ctr[i] >= 2);
    tg = tk ? m_tgt[i] : 64'h0;
  endtask

  task automatic m_train(input logic [63:0] a, input logic [63:0] tg, input bit tk);
    int i;
    i = m_index(a);
    if (m_valid[i] && m_tag[i] == m_tagof(a)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tg;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = m_tagof(a);
      m_tgt[i]   = tg;
      m_ctr[i]   = 2;
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, return at the next negedge.
  task automatic cycle(input bit r, input bit st, input bit rd, input logic [63:0] rdt,
                       input bit tr, input logic [63:0] trt, input bit ue,
                       input logic [63:0] upc, input logic [63:0] utg, input bit utk);
    bit          ptk;
    logic [63:0] ptg;
    rst = r; StallF = st; RedirectE = rd; RedirectTargetE = rdt;
    TrapValid = tr; TrapTarget = trt;
    UpdateEn = ue; UpdatePC = upc; UpdateTarget = utg; UpdateTaken = utk;
    m_pred(m_pc, ptk, ptg);
    @(posedge clk);
    if (!r) begin
      m_pc = RV;
      for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
    end else begin
      if (tr)       m_pc = trt;
      else if (rd)  m_pc = rdt;
      else if (st)  m_pc = m_pc;
      else if (ptk) m_pc = ptg;
      else          m_pc = m_pc + 64'd4;
      if (ue) m_train(upc, utg, utk);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input logic [63:0] a);
    cycle(1, 0, 1, a, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (PC !== RV) begin $display("FAIL reset_pc: got %h want %h", PC, RV); fails++; end
    tests++; if (PredTakenF !== 1'b0) begin $display("FAIL reset_pred: got %b want 0", PredTakenF); fails++; end
    tests++; if (PredTargetF !== 64'h0) begin $display("FAIL reset_predtgt: got %h want 0", PredTargetF); fails++; end
    tests++; if (MisalignF !== 1'b0) begin $display("FAIL reset_misalign: got %b want 0", MisalignF); fails++; end
    idle();
    tests++; if (PC !== 64'h8000_0004) begin $display("FAIL reset_seq1: got %h want 80000004", PC); fails++; end
    idle();
    tests++; if (PC !== 64'h8000_0008) begin $display("FAIL reset_seq2: got %h want 80000008", PC); fails++; end
    tests++; if (PCPlus4 !== 64'h8000_000C) begin $display("FAIL reset_plus4: got %h want 8000000c", PCPlus4); fails++; end
  endtask

  task automatic test_stall_redirect();
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tests++; if (PC !== 64'h8000_0008) begin $display("FAIL stall_hold%0d: got %h want 80000008", k, PC); fails++; end
    end
    cycle(1, 1, 1, 64'h200, 0, 0, 0, 0, 0, 0);
    tests++; if (PC !== 64'h200) begin $display("FAIL stall_redirect: got %h want 200", PC); fails++; end
  endtask

  task automatic test_trap_priority();
    cycle(1, 1, 1, 64'h300, 1, 64'h100, 0, 0, 0, 0);
    tests++; if (PC !== 64'h100) begin $display("FAIL trap_priority: got %h want 100", PC); fails++; end
  endtask

  task automatic test_btb_learn();
    cycle(1, 0, 1, 64'h38, 0, 0, 1, 64'h40, 64'h1000, 1);
    tests++; if (PredTakenF !== 1'b0) begin $display("FAIL learn_nopred38: got %b want 0", PredTakenF); fails++; end
    idle();
    idle();
    tests++; if (PC !== 64'h40) begin $display("FAIL learn_reach40: got %h want 40", PC); fails++; end
    tests++; if (PredTakenF !== 1'b1) begin $display("FAIL learn_pred: got %b want 1", PredTakenF); fails++; end
    tests++; if (PredTargetF !== 64'h1000) begin $display("FAIL learn_predtgt: got %h want 1000", PredTargetF); fails++; end
    idle();
    tests++; if (PC !== 64'h1000) begin $display("FAIL learn_follow: got %h want 1000", PC); fails++; end
    cycle(1, 0, 1, 64'h40, 0, 0, 1, 64'h40, 64'h0, 0);
    tests++; if (PredTakenF !== 1'b0) begin $display("FAIL learn_weaken: got %b want 0", PredTakenF); fails++; end
    idle();
    tests++; if (PC !== 64'h44) begin $display("FAIL learn_seq44: got %h want 44", PC); fails++; end
  endtask

  task automatic test_alias_saturation();
    cycle(1, 0, 1, 64'h440, 0, 0, 1, 64'h40, 64'h1000, 1);
    tests++; if (PC !== 64'h440) begin $display("FAIL alias_pc: got %h want 440", PC); fails++; end
    tests++; if (PredTakenF !== 1'b0) begin $display("FAIL alias_pred: got %b want 0", PredTakenF); fails++; end
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 0, 0, 0, 1, 64'h40, 64'h1000, 1);
    cycle(1, 0, 0, 0, 0, 0, 1, 64'h40, 64'h0, 0);
    redirect(64'h40);
    tests++; if (PredTakenF !== 1'b1) begin $display("FAIL sat_pred: got %b want 1", PredTakenF); fails++; end
    tests++; if (PredTargetF !== 64'h1000) begin $display("FAIL sat_predtgt: got %h want 1000", PredTargetF); fails++; end
    idle();
    tests++; if (PC !== 64'h1000) begin $display("FAIL sat_follow: got %h want 1000", PC); fails++; end
  endtask

  task automatic test_reset_midrun_wrap();
    cycle(0, 0, 1, 64'h40, 0, 0, 1, 64'h40, 64'h2000, 1);
    tests++; if (PC !== RV) begin $display("FAIL midrst_pc: got %h want %h", PC, RV); fails++; end
    redirect(64'h40);
    tests++; if (PredTakenF !== 1'b0) begin $display("FAIL midrst_pred: got %b want 0", PredTakenF); fails++; end
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    tests++; if (PCPlus4 !== 64'h0) begin $display("FAIL wrap_plus4: got %h want 0", PCPlus4); fails++; end
    idle();
    tests++; if (PC !== 64'h0) begin $display("FAIL wrap_pc: got %h want 0", PC); fails++; end
    redirect(64'h202);
    tests++; if (MisalignF !== 1'b1) begin $display("FAIL misalign_set: got %b want 1", MisalignF); fails++; end
    idle();
    tests++; if (PC !== 64'h206) begin $display("FAIL misalign_seq: got %h want 206", PC); fails++; end
    tests++; if (MisalignF !== 1'b1) begin $display("FAIL misalign_hold: got %b want 1", MisalignF); fails++; end
  endtask

  function automatic logic [63:0] pool_addr();
    logic [63:0] bases [3];
    bases[0] = 64'h0; bases[1] = 64'h400; bases[2] = 64'h8000_0000;
    return bases[$urandom_range(0, 2)] + 64'($urandom_range(0, 15) * 4);
  endfunction

  task automatic test_random();
    bit          r, st, rd, tr, ue, utk, etk;
    logic [63:0] rdt, trt, upc, utg, etg;
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 59) != 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      tr  = ($urandom_range(0, 15) == 0);
      ue  = ($urandom_range(0, 2) == 0);
      utk = ($urandom_range(0, 3) != 0);
      rdt = pool_addr() + (($urandom_range(0, 9) == 0) ? 64'd2 : 64'd0);
      trt = pool_addr();
      upc = pool_addr();
      utg = pool_addr();
      cycle(r, st, rd, rdt, tr, trt, ue, upc, utg, utk);
      m_pred(m_pc, etk, etg);
      tests++; if (PC !== m_pc) begin $display("FAIL rnd_pc[%0d]: got %h want %h", n, PC, m_pc); fails++; end
      tests++; if (PCPlus4 !== m_pc + 64'd4) begin $display("FAIL rnd_plus4[%0d]: got %h want %h", n, PCPlus4, m_pc + 64'd4); fails++; end
      tests++; if (PredTakenF !== etk) begin $display("FAIL rnd_pred[%0d]: got %b want %b", n, PredTakenF, etk); fails++; end
      tests++; if (MisalignF !== (m_pc[1:0] != 2'b00)) begin $display("FAIL rnd_misalign[%0d]: got %b want %b", n, MisalignF, m_pc[1:0] != 2'b00); fails++; end
      if (etk) begin
        tests++; if (PredTargetF !== etg) begin $display("FAIL rnd_predtgt[%0d]: got %h want %h", n, PredTargetF, etg); fails++; end
      end
    end
  endtask

  initial begin
    rst = 1'b0; StallF = 1'b0; RedirectE = 1'b0; TrapValid = 1'b0;
    UpdateEn = 1'b0; UpdateTaken = 1'b0;
    RedirectTargetE = '0; TrapTarget = '0; UpdatePC = '0; UpdateTarget = '0;
    m_pc = RV;
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    test_reset();
    test_stall_redirect();
    test_trap_priority();
    test_btb_learn();
    test_alias_saturation();
    test_reset_midrun_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
